// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl
// Debug-side sequencer that walks every register-file address through the
// combinational read port and streams each word out LSB byte first over a
// valid/ready byte channel. It stalls the pipeline and owns the read address
// only while busy.
//
// Optional feature: define REGDUMP_CHECKSUM_EN to append one extra byte after
// the last data byte. That byte is the XOR of every data byte transferred.
//
// Ports:
//   i_clk       clock, all logic on posedge
//   i_rst       asynchronous active-high reset
//   i_start     dump request, sampled only in idle
//   i_abort     cancel the dump from any state
//   i_reg_data  combinational read data for o_reg_addr
//   i_tx_ready  byte channel ready
//   o_reg_addr  register file read address
//   o_tx_data   byte to transmit
//   o_tx_valid  byte valid
//   o_stall     pipeline stall
//   o_busy      dump in progress
//   o_done      one-cycle pulse on normal completion
module regfile_dump_ctrl #(
    parameter int unsigned LEN     = 32,
    parameter int unsigned NB_REG  = 32,
    parameter int unsigned NB_ADDR = 5,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [LEN-1:0]     i_reg_data,
    input  logic               i_tx_ready,
    output logic [NB_ADDR-1:0] o_reg_addr,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_stall,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned NB_WPB = LEN / NB_BYTE;
    localparam int unsigned CNT_W  = (NB_WPB > 1) ? $clog2(NB_WPB) : 1;
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(NB_REG - 1);
    localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(NB_WPB - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSend,
        StCsum,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN-1:0]     shift_q, shift_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               xfer;
`ifdef REGDUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum_q, csum_d;
`endif

    assign xfer = valid_q && i_tx_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (i_abort) begin
            // Abort wins over everything, including a start in idle.
            state_d = StIdle;
            addr_d  = '0;
            cnt_d   = '0;
            shift_d = '0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_d  = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_d = StLatch;
                        addr_d  = '0;
                        cnt_d   = '0;
`ifdef REGDUMP_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                StLatch: begin
                    shift_d = i_reg_data;
                    cnt_d   = '0;
                    state_d = StSend;
                end
                StSend: begin
                    if (xfer) begin
`ifdef REGDUMP_CHECKSUM_EN
                        csum_d = csum_q ^ shift_q[NB_BYTE-1:0];
`endif
                        if (cnt_q != LAST_BYTE) begin
                            shift_d = shift_q >> NB_BYTE;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end else begin
                            cnt_d = '0;
                            if (addr_q != LAST_ADDR) begin
                                addr_d  = addr_q + NB_ADDR'(1);
                                state_d = StLatch;
                            end else begin
`ifdef REGDUMP_CHECKSUM_EN
                                // Checksum byte rides in the low byte of the shifter.
                                shift_d = LEN'(csum_q ^ shift_q[NB_BYTE-1:0]);
                                state_d = StCsum;
`else
                                state_d = StDone;
`endif
                            end
                        end
                    end
                end
                StCsum: begin
                    if (xfer) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
            if (state_d == StDone) begin
                addr_d = '0;
            end
        end
    end

    // Outputs are registered as functions of the next state.
    always_comb begin
        busy_d  = (state_d == StLatch) || (state_d == StSend) || (state_d == StCsum);
        valid_d = (state_d == StSend) || (state_d == StCsum);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign o_reg_addr = addr_q;
    assign o_tx_data  = shift_q[NB_BYTE-1:0];
    assign o_tx_valid = valid_q;
    assign o_busy     = busy_q;
    assign o_stall    = busy_q;
    assign o_done     = done_q;

endmodule

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
- Debug-side sequencer for the register file.
- On request it stalls the pipeline and walks every register address through the register file's combinational read port.
- It streams each 32-bit value out as bytes, LSB first, over a valid/ready byte channel toward the debug UART TX path.
- It sits between the debug unit's command decoder and the register file; it owns the read address only while busy.

Parameters:
- LEN, 32, register width in bits; must be a multiple of 8.
- NB_REG, 32, number of registers dumped.
- NB_ADDR, 5, register address width; 2^NB_ADDR >= NB_REG.
- NB_BYTE, 8, channel byte width; bytes per word NB_WPB = LEN/NB_BYTE.

Ports:
- i_clk  in  1  single clock, all logic on posedge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  dump request pulse; sampled only in IDLE.
- i_abort  in  1  cancel the dump; honoured in any state.
- i_reg_data  in  LEN  combinational read data for o_reg_addr.
- i_tx_ready  in  1  byte channel ready.
- o_reg_addr  out  NB_ADDR  register file read address.
- o_tx_data  out  NB_BYTE  byte to transmit.
- o_tx_valid  out  1  byte valid.
- o_stall  out  1  pipeline stall; high forces pipeline enable low.
- o_busy  out  1  dump in progress.
- o_done  out  1  one-cycle pulse when the dump completes normally.

Behaviour:
- Reset values: state=IDLE, all outputs 0, word and byte counters 0, shift register 0.
- All outputs are registered.
- State IDLE:
  - i_start=1 -> LATCH next cycle.
  - On entry to LATCH: o_busy=1, o_stall=1, o_reg_addr=0.
- State LATCH (1 cycle):
  - Capture i_reg_data into the word shift register; byte counter=0.
  - o_tx_valid=0; o_reg_addr held stable.
  - Next state SEND.
- State SEND:
  - o_tx_valid=1; o_tx_data = shift register [NB_BYTE-1:0].
  - While o_tx_valid && !i_tx_ready: o_tx_data held stable, no state change.
  - On transfer (valid && ready), not last byte: shift right by NB_BYTE, byte counter+1, stay in SEND; valid stays high back-to-back.
  - On transfer, last byte (counter = NB_WPB-1), o_reg_addr != NB_REG-1: o_reg_addr+1, -> LATCH.
  - On transfer, last byte, o_reg_addr == NB_REG-1: -> DONE (or CSUM, see Optional Feature).
- State DONE (1 cycle):
  - o_done=1, o_busy=0, o_stall=0, o_tx_valid=0.
  - o_reg_addr returns to 0; next state IDLE.
- Latency:
  - i_start sampled at cycle 0 -> first o_tx_valid at cycle 2.
  - With i_tx_ready held 1, each word takes 1+NB_WPB cycles.
  - Default parameters: 160 cycles of LATCH/SEND, then DONE at cycle 161.
- i_start while busy: ignored; no restart, no queuing.
- i_abort:
  - From any non-IDLE state -> IDLE next cycle.
  - o_tx_valid, o_busy and o_stall drop; o_done is not pulsed; counters clear.
  - A pending byte is withdrawn, even with valid high.
  - i_abort and i_start together in IDLE: abort wins, stay IDLE.
- Asynchronous reset mid-dump: immediate return to reset values; no o_done.
- Address never exceeds NB_REG-1; no wrap.

Optional Feature:
- Macro: REGDUMP_CHECKSUM_EN.
- Defined:
  - A NB_BYTE running XOR accumulates every transferred byte; cleared on start, abort and reset.
  - After the last data byte, state CSUM presents the accumulator with o_tx_valid=1 under the same handshake rules.
  - On transfer -> DONE.
  - Total bytes = NB_REG*NB_WPB+1.
- Undefined:
  - No CSUM state and no accumulator; the last data byte goes directly to DONE.

Test Plan:
- Registers preloaded so reg[k]=k; pulse i_start; i_tx_ready=1 -> bytes 00,00,00,00,01,00,00,00,...,1F,00,00,00 (128 bytes); o_stall high from cycle 1 to 160; o_done pulse at cycle 161.
- reg[0]=0xDEADBEEF; i_tx_ready toggled 1/0 each cycle -> bytes EF,BE,AD,DE in order; o_tx_data stable during every ready=0 cycle; o_reg_addr=0 during word 0.
- i_abort asserted while the 3rd byte of reg[5] is pending -> next cycle o_tx_valid=0, o_busy=0, o_stall=0, o_reg_addr=0; o_done never pulses.
- i_start re-pulsed at cycle 50 mid-dump -> byte stream identical to an uninterrupted dump; exactly one o_done.
- i_rst asserted asynchronously mid-SEND -> all outputs 0 before the next clock edge; a fresh i_start afterwards produces a full dump.
- REGDUMP_CHECKSUM_EN, reg[k]=k -> 129th byte = XOR of all data bytes = 0x00 (XOR of 0..31); then o_done.
